// File: rtl/k051962_plane_serializer.sv
// k051962_plane_serializer
// Per-plane pixel serializer for the tilemap mixer. One tile slot latches an
// 8-pixel planar GFX ROM word plus its COL attribute. The tile is shifted out
// one dot per pixel enable, with optional horizontal flip. The 0..7 fine
// scroll is applied through a short delay line.
//
// Ports
//   clk_24M      master clock (only clock)
//   RST          synchronous active-high reset
//   PIX_CE       pixel enable; all state advances only when it is high
//   LOAD         tile-slot strobe, honoured with PIX_CE
//   ROM_D        8 pixels, planar: plane b occupies ROM_D[8*b+7 -: 8], MSB = leftmost
//   COL_IN       tile attribute; bit 0 requests H flip
//   FLIP_X_EN    enables COL_IN[0] as H flip
//   FLIP_SCREEN  global flip, XORed into the H flip decision
//   FINE         fine scroll, latched at LOAD
//   DOT          pixel colour index
//   DOT_COL      attribute travelling with DOT
//   DOT_OPAQUE   DOT != 0
//   UNDERRUN     sticky: a tile ran dry before the next LOAD
module k051962_plane_serializer #(
  parameter int unsigned BPP    = 4,
  parameter int unsigned FINE_W = 3,
  parameter int unsigned COL_W  = 8
) (
  input  logic               clk_24M,
  input  logic               RST,
  input  logic               PIX_CE,
  input  logic               LOAD,
  input  logic [8*BPP-1:0]   ROM_D,
  input  logic [COL_W-1:0]   COL_IN,
  input  logic               FLIP_X_EN,
  input  logic               FLIP_SCREEN,
  input  logic [FINE_W-1:0]  FINE,
  output logic [BPP-1:0]     DOT,
  output logic [COL_W-1:0]   DOT_COL,
  output logic               DOT_OPAQUE,
  output logic               UNDERRUN
);

  localparam int unsigned NTaps = 2**FINE_W;

  typedef enum logic [0:0] {StEmpty, StShift} state_e;

  state_e             state_q, state_d;
  logic [8*BPP-1:0]   rom_q;
  logic [COL_W-1:0]   col_q;
  logic               hflip_q;
  logic [FINE_W-1:0]  fine_q;
  logic [2:0]         idx_q;
  logic               loaded_q;
  logic               underrun_q;
  logic [BPP-1:0]     tap_dot_q [NTaps];
  logic [COL_W-1:0]   tap_col_q [NTaps];
  logic [BPP-1:0]     dot_q;
  logic [COL_W-1:0]   dot_col_q;

  logic [BPP-1:0]     pix [8];
  logic [2:0]         pix_sel;
  logic [BPP-1:0]     feed_dot;
  logic [COL_W-1:0]   feed_col;
  logic               underrun_set;

  // Planar decode: pixel p takes bit (7-p) of each 8-bit plane slice.
  always_comb begin
    for (int p = 0; p < 8; p++) begin
      pix[p] = '0;
      for (int b = 0; b < int'(BPP); b++) begin
        pix[p][b] = rom_q[8*b + 7 - p];
      end
    end
  end

  // State register
  always_ff @(posedge clk_24M) begin
    if (RST) begin
      state_q <= StEmpty;
    end else if (PIX_CE) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; only applied on PIX_CE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (LOAD) state_d = StShift;
      StShift: begin
        if (LOAD) begin
          state_d = StShift;
        end else if (idx_q == 3'd7) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // FSM outputs: what is fed into the delay line this pixel
  always_comb begin
    pix_sel      = hflip_q ? (3'd7 - idx_q) : idx_q;
    feed_dot     = '0;
    feed_col     = '0;
    underrun_set = 1'b0;
    unique case (state_q)
      StShift: begin
        feed_dot     = pix[pix_sel];
        feed_col     = col_q;
        // Last pixel fed with no follow-on tile: the next feed is
        // unavoidably from EMPTY, so flag it now.
        underrun_set = (idx_q == 3'd7) && !LOAD;
      end
      StEmpty: underrun_set = loaded_q;
      default: ;
    endcase
  end

  // Tile latch, delay line and output register
  always_ff @(posedge clk_24M) begin
    if (RST) begin
      rom_q      <= '0;
      col_q      <= '0;
      hflip_q    <= 1'b0;
      fine_q     <= '0;
      idx_q      <= '0;
      loaded_q   <= 1'b0;
      underrun_q <= 1'b0;
      dot_q      <= '0;
      dot_col_q  <= '0;
      for (int i = 0; i < int'(NTaps); i++) begin
        tap_dot_q[i] <= '0;
        tap_col_q[i] <= '0;
      end
    end else if (PIX_CE) begin
      if (LOAD) begin
        rom_q    <= ROM_D;
        col_q    <= COL_IN;
        hflip_q  <= (COL_IN[0] & FLIP_X_EN) ^ FLIP_SCREEN;
        fine_q   <= FINE;
        idx_q    <= '0;
        loaded_q <= 1'b1;
      end else if (state_q == StShift) begin
        idx_q <= idx_q + 3'd1;
      end
      if (underrun_set) underrun_q <= 1'b1;
      tap_dot_q[0] <= feed_dot;
      tap_col_q[0] <= feed_col;
      for (int i = 1; i < int'(NTaps); i++) begin
        tap_dot_q[i] <= tap_dot_q[i-1];
        tap_col_q[i] <= tap_col_q[i-1];
      end
      // Reads the tap using the FINE in force before this edge
      dot_q     <= tap_dot_q[fine_q];
      dot_col_q <= tap_col_q[fine_q];
    end
  end

  assign DOT        = dot_q;
  assign DOT_COL    = dot_col_q;
  assign DOT_OPAQUE = |dot_q;
  assign UNDERRUN   = underrun_q;

endmodule
